// File: rtl/rf_pkg.sv
// Types and defaults for the integer register file. Decode and writeback share
// these types to name registers and words.
package rf_pkg;

    localparam int RF_XLEN_D  = 32;
    localparam int RF_NREGS_D = 32;
    localparam int RF_NRD_D   = 2;

    function automatic int rf_clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

    localparam int RF_AW_D = rf_clog2(RF_NREGS_D);

    typedef logic [RF_AW_D-1:0]   reg_addr_t;
    typedef logic [RF_XLEN_D-1:0] word_t;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: write-first bypass, hardwired-zero check, and
// lookup of the post-update pending flag of the addressed register.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN_D,
    parameter int NREGS    = RF_NREGS_D,
    parameter int ZERO_REG = 1,
    parameter int AW       = rf_clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   i_addr,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic [XLEN-1:0] i_rf [NREGS],
    input  logic [NREGS-1:0] i_pend_next,
    output logic [XLEN-1:0] o_data,
    output logic            o_busy
);

    logic [XLEN-1:0] w_data_p0;
    logic [XLEN-1:0] r_data_p1;
    logic            r_busy_p1;

    // Bypass beats storage; the zero register beats everything.
    always_comb begin
        w_data_p0 = i_rf[i_addr];
        if (i_we && (i_wr_addr == i_addr)) w_data_p0 = i_wr_data;
        if ((ZERO_REG != 0) && (i_addr == '0)) w_data_p0 = '0;
    end

    // p0 -> p1: registered read outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_p1 <= '0;
            r_busy_p1 <= 1'b0;
        end else begin
            r_data_p1 <= w_data_p0;
            r_busy_p1 <= i_pend_next[i_addr];
        end
    end

    assign o_data = r_data_p1;
    assign o_busy = r_busy_p1;

endmodule

// File: rtl/rf_multiport.sv
// Multi-read-port integer register file with a per-register pending-write
// scoreboard used by decode for RAW hazard detection.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN_D,
    parameter int NREGS    = RF_NREGS_D,
    parameter int NRD      = RF_NRD_D,
    parameter int ZERO_REG = 1,
    localparam int AW      = rf_clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    input  logic              flush,
    output logic [AW:0]       pend_cnt
);

    logic [XLEN-1:0]  r_rf [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [AW:0]      r_pend_cnt;

    logic             w_wr_ok;
    logic             w_alloc_ok;
    logic             w_inc;
    logic             w_dec;
    logic [NREGS-1:0] w_pend_next;

    assign w_wr_ok    = we && !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

    // Order matters: write-clear, then alloc-set (younger instruction), then flush.
    always_comb begin
        w_pend_next = r_pend;
        if (w_wr_ok)    w_pend_next[wr_addr]    = 1'b0;
        if (w_alloc_ok) w_pend_next[alloc_addr] = 1'b1;
        if (flush)      w_pend_next             = '0;
    end

    // Counter tracks the bit deltas; a write+alloc on one pending register nets zero.
    assign w_inc = w_alloc_ok && !r_pend[alloc_addr];
    assign w_dec = w_wr_ok && r_pend[wr_addr] && !(w_alloc_ok && (alloc_addr == wr_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) r_rf[k] <= '0;
        end else if (w_wr_ok) begin
            r_rf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (flush) r_pend_cnt <= '0;
            else       r_pend_cnt <= r_pend_cnt + {{AW{1'b0}}, w_inc} - {{AW{1'b0}}, w_dec};
        end
    end

    assign pend_cnt = r_pend_cnt;

    for (genvar g = 0; g < NRD; g++) begin : g_port
        rf_read_port #(
            .XLEN     (XLEN),
            .NREGS    (NREGS),
            .ZERO_REG (ZERO_REG),
            .AW       (AW)
        ) u_port (
            .clk         (clk),
            .rst         (rst),
            .i_addr      (rd_addr[g*AW +: AW]),
            .i_we        (we),
            .i_wr_addr   (wr_addr),
            .i_wr_data   (wr_data),
            .i_rf        (r_rf),
            .i_pend_next (w_pend_next),
            .o_data      (rd_data[g*XLEN +: XLEN]),
            .o_busy      (rd_busy[g])
        );
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport (NREGS=16, NRD=4, XLEN=64): directed scenarios plus
// random traffic checked against an array-based reference model.
module tb_rf_multiport;

    localparam int XLEN  = 64;
    localparam int NREGS = 16;
    localparam int NRD   = 4;
    localparam int AW    = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 we;
    logic [AW-1:0]        wr_addr;
    logic [XLEN-1:0]      wr_data;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_addr;
    logic                 flush;
    logic [AW:0]          pend_cnt;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0]  m_rf [NREGS];
    logic [NREGS-1:0] m_pend;

    rf_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .pend_cnt   (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREGS; k++) m_rf[k] = '0;
        m_pend = '0;
    endtask

    // Apply current inputs for one edge, advance the model, then check all outputs.
    task automatic step();
        logic [XLEN-1:0] exp_d [NRD];
        logic            exp_b [NRD];
        int              a;
        for (int p = 0; p < NRD; p++) begin
            a = int'(rd_addr[p*AW +: AW]);
            if (a == 0)                          exp_d[p] = '0;
            else if (we && int'(wr_addr) == a)   exp_d[p] = wr_data;
            else                                 exp_d[p] = m_rf[a];
        end
        if (we && wr_addr != 0) begin
            m_rf[wr_addr]   = wr_data;
            m_pend[wr_addr] = 1'b0;
        end
        if (alloc_en && alloc_addr != 0) m_pend[alloc_addr] = 1'b1;
        if (flush) m_pend = '0;
        for (int p = 0; p < NRD; p++) exp_b[p] = m_pend[rd_addr[p*AW +: AW]];
        @(posedge clk);
        #1;
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("rd_data%0d", p), 64'(rd_data[p*XLEN +: XLEN]), 64'(exp_d[p]));
            chk($sformatf("rd_busy%0d", p), 64'(rd_busy[p]), 64'(exp_b[p]));
        end
        chk("pend_cnt", 64'(pend_cnt), 64'($countones(m_pend)));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, 64'(|rd_data), 64'd0);
        chk({tag, "_busy"}, 64'(rd_busy), 64'd0);
        chk({tag, "_cnt"},  64'(pend_cnt), 64'd0);
    endtask

    int prev_cnt;

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        idle();
        model_reset();
        #2;
        chk_all_zero("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-operation
        we = 1'b1; wr_addr = 4'd5; wr_data = 64'hDEADBEEF;
        step();
        idle();
        alloc_en = 1'b1; alloc_addr = 4'd7;
        for (int p = 0; p < NRD; p++) set_rd(p, (p == 1) ? 7 : 5);
        step();
        idle();
        step();
        chk("pre_rst_r5", 64'(rd_data[0 +: XLEN]), 64'hDEADBEEF);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_all_zero("reset_async");
        #1;
        rst = 1'b0;
        for (int p = 0; p < NRD; p++) set_rd(p, 5);
        step();
        chk("post_rst_r5", 64'(rd_data[0 +: XLEN]), 64'd0);

        // Bypass: write r3 while reading it
        we = 1'b1; wr_addr = 4'd3; wr_data = 64'h12345678;
        for (int p = 0; p < NRD; p++) set_rd(p, 3);
        step();
        chk("bypass_p0", 64'(rd_data[0 +: XLEN]), 64'h12345678);
        chk("bypass_p1", 64'(rd_data[XLEN +: XLEN]), 64'h12345678);
        idle();

        // Zero register ignores write and alloc
        prev_cnt = $countones(m_pend);
        we = 1'b1; wr_addr = 4'd0; wr_data = '1;
        alloc_en = 1'b1; alloc_addr = 4'd0;
        for (int p = 0; p < NRD; p++) set_rd(p, 0);
        step();
        idle();
        step();
        chk("zero_data", 64'(rd_data[0 +: XLEN]), 64'd0);
        chk("zero_busy", 64'(rd_busy), 64'd0);
        chk("zero_cnt", 64'(pend_cnt), 64'(prev_cnt));

        // Scoreboard sequence
        alloc_en = 1'b1; alloc_addr = 4'd4; step();
        alloc_addr = 4'd9; step();
        chk("sb_cnt2", 64'(pend_cnt), 64'd2);
        idle();
        set_rd(0, 4); set_rd(1, 9);
        step();
        chk("sb_busy_r4", 64'(rd_busy[0]), 64'd1);
        we = 1'b1; wr_addr = 4'd4; wr_data = 64'hA5A5;
        alloc_en = 1'b1; alloc_addr = 4'd4;
        step();
        chk("sb_wa_cnt", 64'(pend_cnt), 64'd2);
        chk("sb_wa_busy", 64'(rd_busy[0]), 64'd1);
        idle();
        we = 1'b1; wr_addr = 4'd9; wr_data = 64'h99;
        step();
        chk("sb_w9_cnt", 64'(pend_cnt), 64'd1);
        idle();

        // Flush overrides a same-cycle alloc
        alloc_en = 1'b1; alloc_addr = 4'd2; step();
        alloc_addr = 4'd6; step();
        alloc_addr = 4'd10; flush = 1'b1;
        set_rd(0, 2); set_rd(1, 6); set_rd(2, 10); set_rd(3, 4);
        step();
        chk("flush_cnt", 64'(pend_cnt), 64'd0);
        chk("flush_busy", 64'(rd_busy), 64'd0);
        idle();

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            we         = ($urandom_range(0, 1) == 1);
            wr_addr    = AW'($urandom_range(0, NREGS - 1));
            wr_data    = {$urandom, $urandom};
            alloc_en   = ($urandom_range(0, 1) == 1);
            alloc_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
            flush      = ($urandom_range(0, 31) == 0);
            for (int p = 0; p < NRD; p++)
                set_rd(p, ($urandom_range(0, 3) == 0) ? int'(wr_addr) : int'($urandom_range(0, NREGS - 1)));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised successor to the core's 2-read/1-write integer register file. It provides NRD registered read ports with write-first bypass and an optional hardwired-zero register. It also holds a per-register pending-write scoreboard (alloc on issue, clear on writeback, bulk flush) so the decode stage can detect RAW hazards. It sits between decode (read/alloc) and writeback (write) in the RV32I pipeline.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, ≥ 2
- NRD, 2, number of read ports, 1..4
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores write/alloc
- AW, derived, clog2(NREGS)

Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  registered read data, port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  registered pending flag of the addressed register
- we  in  1  write enable
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- alloc_en  in  1  mark alloc_addr as pending a write
- alloc_addr  in  AW  register to mark
- flush  in  1  clear all pending flags (pipeline squash)
- pend_cnt  out  AW+1  number of registers currently pending

## Operation
- Storage: NREGS × XLEN flops, plus NREGS pending bits.
- Write: on a clock edge with we=1, rf[wr_addr] ← wr_data and pend[wr_addr] ← 0. Both are suppressed when ZERO_REG=1 and wr_addr=0.
- Alloc: on a clock edge with alloc_en=1, pend[alloc_addr] ← 1. Ignored for address 0 when ZERO_REG=1.
- Write and alloc to the same address in the same cycle: data is written and pend ends at 1, because the new allocation belongs to a younger instruction.
- Flush: all pend ← 0 and overrides any alloc in the same cycle. A write in the same cycle still updates data.
- Read port i, sampled each edge:
  - rd_data[i] ← 0 if ZERO_REG and addr=0.
  - Otherwise rd_data[i] ← wr_data if we and wr_addr==addr (write-first bypass).
  - Otherwise rd_data[i] ← rf[addr].
- rd_busy[i] reflects the pend value after this edge's updates: write-clear, then alloc-set, then flush-clear.
- Read ports are independent. All ports may address the same register.
- pend_cnt is a registered counter updated each edge:
  - +1 if an alloc sets a bit that was 0.
  - −1 if a write clears a bit that was 1.
  - Net 0 when both happen on the same address.
  - Forced to 0 on flush.
  - Must always equal popcount(pend). It never exceeds NREGS−ZERO_REG and never wraps.

## Timing
- Read latency: 1 cycle from address to rd_data/rd_busy.
- Write to read of the same register in the same cycle: new data is returned with no extra cycle (bypass).
- No handshake: every operation completes in one edge, with no stall or back-pressure.
- Reset (rst=1, at any time, including mid-operation): all rf entries = 0, all pend = 0, rd_data = 0, rd_busy = 0, pend_cnt = 0, immediately and asynchronously.
- On the first edge after rst deasserts, normal operation resumes. Writes presented during reset are lost.

## Structure
- Shared package rf_pkg holds:
  - default XLEN/NREGS/NRD constants
  - the AW derivation function (clog2)
  - the reg_addr_t and word_t typedefs, also used by decode and writeback
- One natural sub-module, rf_read_port: mux + bypass + zero-check + busy lookup, instantiated NRD times in a generate loop.
- Storage, the pend vector and the pend_cnt counter live in the top.

## Test plan
- Reset: load r5=0xDEADBEEF and alloc r7, then pulse rst mid-cycle. Required: all outputs 0 at once; reading r5 after release returns 0; pend_cnt=0.
- Bypass: we=1, wr_addr=3, wr_data=0x12345678, and both read ports address 3 in the same cycle. Required: the next cycle rd_data port0 = port1 = 0x12345678.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 and alloc r0. Required: reads of r0 return 0, rd_busy=0, pend_cnt unchanged.
- Scoreboard sequence:
  - alloc r4, alloc r9 → pend_cnt=2.
  - Read r4 → rd_busy=1.
  - Write r4 with alloc r4 in the same cycle → pend_cnt stays 2, r4 still busy.
  - Write r9 → pend_cnt=1.
- Flush precedence: alloc r10 and flush in the same cycle, with pending r2 and r6. Required: pend_cnt=0, all rd_busy=0.
- Parameter sweep (NREGS=16, NRD=4, XLEN=64): random write/alloc/flush traffic for 10k cycles checked against a reference model. Required: every rd_data matches the model, and pend_cnt always equals popcount(pend).
